// File: rtl/cursor_coord_gen.sv
// Cell-index to pixel coordinate generator: single offset point with edge
// saturation, or a row-major sweep of a square brush footprint, on valid/ready.
module cursor_coord_gen #(
    parameter int IDX_W      = 6,
    parameter int SCALE_LOG2 = 2,
    parameter int OFF_W      = 3,
    parameter int OUT_W      = 9,
    parameter int MAX_X      = 255,
    parameter int MAX_Y      = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             sum,
    input  logic             axis,
    input  logic [OFF_W-1:0] c,
    input  logic [OFF_W-1:0] radius,
    input  logic [IDX_W-1:0] in_x,
    input  logic [IDX_W-1:0] in_y,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_x,
    output logic [OUT_W-1:0] out_y,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int W = OUT_W + 2;
    localparam logic signed [W-1:0] ZERO_S  = {W{1'b0}};
    localparam logic signed [W-1:0] ONE_S   = {{(W-1){1'b0}}, 1'b1};
    localparam logic signed [W-1:0] MAX_X_S = W'(MAX_X);
    localparam logic signed [W-1:0] MAX_Y_S = W'(MAX_Y);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_SWEEP  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic logic [OUT_W-1:0] clamp_px(input logic signed [W-1:0] v,
                                                  input logic signed [W-1:0] vmax);
        logic signed [W-1:0] t;
        if (v < ZERO_S) begin
            t = ZERO_S;
        end else if (v > vmax) begin
            t = vmax;
        end else begin
            t = v;
        end
        return OUT_W'(t);
    endfunction

    state_t                   state_q, state_d;
    logic signed [W-1:0]      bx_q, bx_d, by_q, by_d;
    logic signed [W-1:0]      dx_q, dx_d, dy_q, dy_d;
    logic        [OFF_W-1:0]  r_q, r_d;
    logic                     last_q, last_d;
    logic        [OUT_W-1:0]  out_x_q, out_x_d, out_y_q, out_y_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d, done_q, done_d;

    logic signed [W-1:0]      base_x_s, base_y_s, c_s, r_in_s, r_lat_s;
    logic signed [W-1:0]      off_x_s, off_y_s, cand_x_s, cand_y_s;
    logic                     adv_s, in_range_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        r_d         = r_q;
        last_d      = last_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;

        base_x_s   = W'(in_x) << SCALE_LOG2;
        base_y_s   = W'(in_y) << SCALE_LOG2;
        c_s        = W'(c);
        r_in_s     = W'(radius);
        r_lat_s    = W'(r_q);
        off_x_s    = sum ? (base_x_s + c_s) : (base_x_s - c_s);
        off_y_s    = sum ? (base_y_s + c_s) : (base_y_s - c_s);
        cand_x_s   = bx_q + dx_q;
        cand_y_s   = by_q + dy_q;
        adv_s      = !out_valid_q || out_ready;
        in_range_s = (cand_x_s >= ZERO_S) && (cand_x_s <= MAX_X_S) &&
                     (cand_y_s >= ZERO_S) && (cand_y_s <= MAX_Y_S);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bx_d = base_x_s;
                    by_d = base_y_s;
                    r_d  = radius;
                    if (!mode) begin
                        state_d     = ST_SINGLE;
                        out_valid_d = 1'b1;
                        if (!axis) begin
                            out_x_d = clamp_px(off_x_s, MAX_X_S);
                            out_y_d = clamp_px(base_y_s, MAX_Y_S);
                        end else begin
                            out_x_d = clamp_px(base_x_s, MAX_X_S);
                            out_y_d = clamp_px(off_y_s, MAX_Y_S);
                        end
                    end else begin
                        state_d     = ST_SWEEP;
                        dx_d        = -r_in_s;
                        dy_d        = -r_in_s;
                        last_d      = 1'b0;
                        out_valid_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SINGLE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FINISH;
                end else begin
                    state_d = ST_SINGLE;
                end
            end
            ST_SWEEP: begin
                if (!adv_s) begin
                    state_d = ST_SWEEP;
                end else if (last_q) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FINISH;
                end else begin
                    // Off-screen slots are dropped, not clamped: one idle cycle each
                    if (in_range_s) begin
                        out_x_d     = OUT_W'(cand_x_s);
                        out_y_d     = OUT_W'(cand_y_s);
                        out_valid_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                    if (dx_q == r_lat_s) begin
                        if (dy_q == r_lat_s) begin
                            last_d = 1'b1;
                        end else begin
                            dx_d = -r_lat_s;
                            dy_d = dy_q + ONE_S;
                        end
                    end else begin
                        dx_d = dx_q + ONE_S;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        done_d = (state_d == ST_FINISH);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, updated on the falling edge of the cursor path
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bx_q        <= ZERO_S;
            by_q        <= ZERO_S;
            dx_q        <= ZERO_S;
            dy_q        <= ZERO_S;
            r_q         <= {OFF_W{1'b0}};
            last_q      <= 1'b0;
            out_x_q     <= {OUT_W{1'b0}};
            out_y_q     <= {OUT_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            r_q         <= r_d;
            last_q      <= last_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cursor_coord_gen.sv
// Directed and randomized bench for cursor_coord_gen against a point-list model.
module tb_cursor_coord_gen;

    logic       clk = 1'b0;
    logic       rst, start, start_b, mode, sum, axis, out_ready;
    logic [2:0] c, radius;
    logic [5:0] in_x, in_y;
    logic [8:0] out_x, out_y, outb_x, outb_y;
    logic       out_valid, busy, done, outb_valid, busyb, doneb;

    int checks = 0;
    int errors = 0;
    int exp_x[$];
    int exp_y[$];

    always #5 clk = ~clk;

    cursor_coord_gen dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .sum(sum), .axis(axis),
        .c(c), .radius(radius), .in_x(in_x), .in_y(in_y), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .busy(busy), .done(done)
    );

    cursor_coord_gen #(.MAX_X(250)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .sum(sum), .axis(axis),
        .c(c), .radius(radius), .in_x(in_x), .in_y(in_y), .out_ready(out_ready),
        .out_x(outb_x), .out_y(outb_y), .out_valid(outb_valid), .busy(busyb), .done(doneb)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int clampi(input int v, input int m);
        return (v < 0) ? 0 : ((v > m) ? m : v);
    endfunction

    // Reference: list of points the operation must deliver, in order
    task automatic build_exp(input bit m, input bit s, input bit a,
                             input int cc, input int rr, input int ix, input int iy);
        int bx, by, off;
        exp_x.delete();
        exp_y.delete();
        bx = ix * 4;
        by = iy * 4;
        if (!m) begin
            off = s ? cc : -cc;
            exp_x.push_back(a ? clampi(bx, 255) : clampi(bx + off, 255));
            exp_y.push_back(a ? clampi(by + off, 255) : clampi(by, 255));
        end else begin
            for (int dy = -rr; dy <= rr; dy++)
                for (int dx = -rr; dx <= rr; dx++)
                    if (bx + dx >= 0 && bx + dx <= 255 && by + dy >= 0 && by + dy <= 255) begin
                        exp_x.push_back(bx + dx);
                        exp_y.push_back(by + dy);
                    end
        end
    endtask

    // rmode: 0 ready high, 1 random ready, 2 stall 3 cycles on the 2nd point
    task automatic run_op(input bit m, input bit s, input bit a, input int cc, input int rr,
                          input int ix, input int iy, input int rmode, input int exp_cyc,
                          input bit poke, input string tag);
        int  idx, done_cnt, done_cyc, hold_cnt, vcyc, px, py;
        bit  prev_hold;
        idx = 0; done_cnt = 0; done_cyc = 0; hold_cnt = 0; vcyc = 0; px = 0; py = 0;
        prev_hold = 1'b0;
        build_exp(m, s, a, cc, rr, ix, iy);
        @(posedge clk);
        mode = m; sum = s; axis = a; c = cc[2:0]; radius = rr[2:0];
        in_x = ix[5:0]; in_y = iy[5:0]; start = 1'b1; out_ready = 1'b1;
        for (int cyc = 1; cyc <= 2000 && done_cnt == 0; cyc++) begin
            @(posedge clk);
            if (cyc == 1) begin
                start  = poke;
                mode   = 1'($urandom_range(0, 1));
                sum    = 1'($urandom_range(0, 1));
                axis   = 1'($urandom_range(0, 1));
                c      = 3'($urandom_range(0, 7));
                radius = 3'($urandom_range(0, 7));
                in_x   = 6'($urandom_range(0, 63));
                in_y   = 6'($urandom_range(0, 63));
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk({tag, "_done_valid"}, out_valid, 0);
            end
            chk({tag, "_busy"}, busy, 1);
            if (prev_hold) begin
                chk({tag, "_hold_v"}, out_valid, 1);
                chk({tag, "_hold_x"}, out_x, px);
                chk({tag, "_hold_y"}, out_y, py);
            end else if (out_valid) begin
                if (idx < exp_x.size()) begin
                    chk({tag, "_x"}, out_x, exp_x[idx]);
                    chk({tag, "_y"}, out_y, exp_y[idx]);
                end else begin
                    chk({tag, "_extra_point"}, 1, 0);
                end
            end
            if (out_valid) vcyc++;
            if (rmode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else if (rmode == 2 && idx == 1 && out_valid && hold_cnt < 3) begin
                out_ready = 1'b0;
                hold_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            prev_hold = out_valid && !out_ready;
            px = out_x;
            py = out_y;
            if (out_valid && out_ready) idx++;
        end
        start = 1'b0;
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_points"}, idx, exp_x.size());
        if (exp_cyc >= 0) chk({tag, "_done_cycle"}, done_cyc, exp_cyc);
        if (!m && rmode == 0) chk({tag, "_valid_cycles"}, vcyc, 1);
        if (rmode == 2) chk({tag, "_stall_cycles"}, hold_cnt, 3);
        @(posedge clk);
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_busy_drop"}, busy, 0);
    endtask

    initial begin
        int acc;
        rst = 1'b1; start = 1'b0; start_b = 1'b0; mode = 1'b0; sum = 1'b0; axis = 1'b0;
        c = 3'd0; radius = 3'd0; in_x = 6'd0; in_y = 6'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // Saturation at a narrower right edge
        @(posedge clk);
        mode = 1'b0; sum = 1'b1; axis = 1'b0; c = 3'd7; in_x = 6'd63; in_y = 6'd2;
        out_ready = 1'b1; start_b = 1'b1;
        @(posedge clk);
        start_b = 1'b0;
        chk("sat250_valid", outb_valid, 1);
        chk("sat250_x", outb_x, 250);
        chk("sat250_y", outb_y, 8);
        repeat (3) @(posedge clk);
        chk("sat250_idle", busyb, 0);

        run_op(1'b0, 1'b1, 1'b0, 3, 0, 10, 5, 0, 2, 1'b0, "single_add");
        run_op(1'b0, 1'b0, 1'b0, 3, 0, 0, 7, 0, 2, 1'b0, "single_sub_sat");
        run_op(1'b0, 1'b1, 1'b1, 5, 0, 20, 63, 0, 2, 1'b0, "single_y_sat");
        run_op(1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 0, 11, 1'b0, "sweep_corner");
        run_op(1'b1, 1'b0, 1'b0, 0, 1, 10, 10, 2, -1, 1'b0, "sweep_bp");
        run_op(1'b1, 1'b0, 1'b0, 0, 0, 7, 9, 0, 3, 1'b1, "sweep_r0_poke");

        // Abort a sweep with reset after the third accepted point
        build_exp(1'b1, 1'b0, 1'b0, 0, 2, 20, 20);
        @(posedge clk);
        mode = 1'b1; radius = 3'd2; in_x = 6'd20; in_y = 6'd20; out_ready = 1'b1; start = 1'b1;
        acc = 0;
        for (int cyc = 0; cyc < 50 && acc < 3; cyc++) begin
            @(posedge clk);
            start = 1'b0;
            if (out_valid) begin
                chk("abort_x", out_x, exp_x[acc]);
                chk("abort_y", out_y, exp_y[acc]);
                acc++;
            end
        end
        chk("abort_reached3", acc, 3);
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        chk("abort_x0", out_x, 0);
        chk("abort_y0", out_y, 0);
        chk("abort_valid0", out_valid, 0);
        chk("abort_busy0", busy, 0);
        chk("abort_done0", done, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        run_op(1'b0, 1'b1, 1'b1, 2, 0, 3, 4, 0, 2, 1'b0, "after_abort");

        for (int t = 0; t < 8; t++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                   1, -1, 1'b0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cursor_coord_gen.md
Name: cursor_coord_gen

Overview:
- Parametrised successor of the palette-cursor X adjuster. Converts a cell index pair (in_x, in_y) into pixel coordinates scaled by 2^SCALE_LOG2.
- Two modes:
  - Single-point mode: offset ±c on a selectable axis, with saturation at the screen edges.
  - Sweep mode: walks a (2r+1)x(2r+1) brush footprint around the scaled point.
- Sits between cursor/palette control and the framebuffer writer, which consumes points over a valid/ready handshake.

Parameters:
- IDX_W, 6, width of in_x/in_y cell indices
- SCALE_LOG2, 2, cell-to-pixel scale (base = idx << SCALE_LOG2)
- OFF_W, 3, width of c and radius
- OUT_W, 9, width of out_x/out_y
- MAX_X, 255, largest legal pixel x
- MAX_Y, 255, largest legal pixel y

Ports:
- clk  in  1  clock; all state updates on the falling edge (same edge as the rest of the cursor path)
- rst  in  1  synchronous, active-high reset
- start  in  1  begin operation; sampled only in IDLE
- mode  in  1  0 = single point, 1 = sweep
- sum  in  1  single mode: 1 = add c, 0 = subtract c
- axis  in  1  single mode: 0 = offset x, 1 = offset y
- c  in  OFF_W  single-mode offset
- radius  in  OFF_W  sweep half-size r
- in_x  in  IDX_W  cell x index
- in_y  in  IDX_W  cell y index
- out_ready  in  1  consumer accepts the current point
- out_x  out  OUT_W  pixel x
- out_y  out  OUT_W  pixel y
- out_valid  out  1  out_x/out_y hold a valid point
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the operation completes

Behaviour:
- Reset: on any active edge with rst=1, state is IDLE and out_x, out_y, out_valid, busy, done are all 0.
  - rst has priority over everything.
  - rst mid-operation aborts with no done pulse; the in-flight point is dropped.
- Arithmetic:
  - bx = in_x << SCALE_LOG2 and by = in_y << SCALE_LOG2, computed in signed OUT_W+2 bits.
  - No wrap-around anywhere.
- Inputs are latched on the start edge: in_x, in_y, mode, sum, axis, c, radius. Later input changes have no effect until the next start.
- start while busy=1 is ignored.
- States: IDLE, SINGLE, SWEEP, FINISH.
- IDLE:
  - On start with mode=0: go to SINGLE. On the same edge:
    - the selected axis coordinate = clamp(base ± c, 0, MAX);
    - the other axis coordinate = clamp(base, 0, MAX);
    - out_valid=1.
  - On start with mode=1: go to SWEEP with dy=-r, dx=-r.
- SINGLE: hold outputs stable until an edge with out_ready=1. On that edge: out_valid=0, go to FINISH.
- SWEEP:
  - Candidate point is (bx+dx, by+dy). Order is row-major: dy outer from -r to +r, dx inner from -r to +r. Total (2r+1)^2 slots.
  - The walk advances on any edge where out_valid=0 or out_ready=1.
  - On each advance, the next candidate is evaluated:
    - In range (0 ≤ px ≤ MAX_X and 0 ≤ py ≤ MAX_Y): load out_x/out_y, set out_valid=1.
    - Out of range: skipped. It costs exactly one cycle with out_valid=0; no clamping in sweep mode.
  - Once the last slot has been consumed (accepted, or skipped), go to FINISH on the next advance edge, with out_valid=0.
- FINISH: done=1 for exactly one cycle, then IDLE. busy drops on the same edge that done drops.
- Backpressure: while out_valid=1 and out_ready=0, out_x, out_y and out_valid are held unchanged.
- Latency:
  - The first point is visible one edge after start in single mode.
  - In sweep mode the first slot is evaluated on the edge after start.
  - With out_ready tied high and no skips, one point per cycle; done follows the last point by one cycle.
- radius=0 sweep: one slot only, the point (bx, by).

Test Plan:
- Single add, x axis: mode=0, sum=1, axis=0, in_x=10, in_y=5, c=3, out_ready=1 -> out_x=43, out_y=20, out_valid for 1 cycle, then done pulse, busy low.
- Single subtract with saturation: in_x=0, c=3, sum=0 -> out_x=0 (not 509). In a second run, set MAX_X=250, in_x=63, c=7, sum=1 -> out_x=250.
- Sweep at corner: in_x=0, in_y=0, r=1, out_ready=1 -> emits exactly (0,0), (1,0), (0,1), (1,1) in that order; 5 skipped slots; done after 9 slots.
- Sweep backpressure: in_x=10, in_y=10, r=1; drop out_ready for 3 cycles while the 2nd point (40,39) is valid -> point held stable, none lost or duplicated, 9 points total.
- radius=0 sweep plus start while busy: exactly one point (4*in_x, 4*in_y); a second start pulsed during the operation is ignored.
- Reset mid-sweep: assert rst after the 3rd accepted point -> next edge has all outputs 0 and state IDLE, no done; a fresh start works normally.
